fifo_wr_arbiter: RTL and testbench

//  Write-side controller and 2:1 round-robin arbiter for the dual-clock FIFO memory.
//  - Two write sources use valid/ready handshakes and share the memory's single write port.
//  - Drives the memory write enable, address and data.
//  - Maintains the binary/Gray write pointer and derives FULL from the read pointer, already synchronised into WR_CLK.
//

---
 rtl/fifo_wr_arbiter_if.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 99 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle of the dual-clock FIFO: two requester handshakes, the
// synchronised read pointer, and the memory write port / flags driven back.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_DATA  = 3
);
  logic                  REQ0_VALID;
  logic [DATA_WIDTH-1:0] REQ0_DATA;
  logic                  REQ0_READY;
  logic                  REQ1_VALID;
  logic [DATA_WIDTH-1:0] REQ1_DATA;
  logic                  REQ1_READY;
  logic [ADDR_DATA:0]    RD_PTR_SYNC;
  logic                  WR_CLK_EN;
  logic [ADDR_DATA-1:0]  WR_addr;
  logic [DATA_WIDTH-1:0] WR_data;
  logic [ADDR_DATA:0]    WR_PTR_GRAY;
  logic                  FULL;
  logic                  GRANT_ID;
  logic                  ALMOST_FULL;

  modport master (
    output REQ0_VALID, REQ0_DATA, REQ1_VALID, REQ1_DATA, RD_PTR_SYNC,
    input  REQ0_READY, REQ1_READY, WR_CLK_EN, WR_addr, WR_data,
           WR_PTR_GRAY, FULL, GRANT_ID, ALMOST_FULL
  );

  modport slave (
    input  REQ0_VALID, REQ0_DATA, REQ1_VALID, REQ1_DATA, RD_PTR_SYNC,
    output REQ0_READY, REQ1_READY, WR_CLK_EN, WR_addr, WR_data,
           WR_PTR_GRAY, FULL, GRANT_ID, ALMOST_FULL
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller with 2:1 round-robin arbitration for the dual-clock FIFO.
// Optional occupancy-based ALMOST_FULL is built only when FIFO_WR_ALMOST_FULL_EN is defined.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_DATA  = 3,
  parameter int AF_THRESH  = 6
) (
  input  logic             WR_CLK,
  input  logic             WR_RST,
  fifo_wr_arbiter_if.slave wr
);

  logic [ADDR_DATA:0] wptr_bin_reg;
  logic [ADDR_DATA:0] wptr_bin_next;
  logic [ADDR_DATA:0] wptr_gray_reg;
  logic [ADDR_DATA:0] wptr_gray_next;
  logic [ADDR_DATA:0] full_match;
  logic               last_reg;
  logic               full_reg;
  logic               grant_id;
  logic               grant_valid;
  logic               accept;

  if (ADDR_DATA < 2 || AF_THRESH < 1 || AF_THRESH > (2 ** ADDR_DATA)) begin : g_param_check
    $error("fifo_wr_arbiter: ADDR_DATA must be >= 2 and AF_THRESH within 1..2**ADDR_DATA");
  end

  // Round robin: on a tie the requester not served last wins.
  always_comb begin
    grant_id = 1'b0;
    if (wr.REQ0_VALID && wr.REQ1_VALID) begin
      grant_id = ~last_reg;
    end else if (wr.REQ1_VALID) begin
      grant_id = 1'b1;
    end
  end

  assign grant_valid   = grant_id ? wr.REQ1_VALID : wr.REQ0_VALID;
  // Reset level gates the handshake so a burst cut by reset never half-writes.
  assign wr.REQ0_READY = WR_RST & ~full_reg & ~grant_id;
  assign wr.REQ1_READY = WR_RST & ~full_reg & grant_id;
  assign accept        = WR_RST & ~full_reg & grant_valid;

  assign wr.WR_CLK_EN   = accept;
  assign wr.GRANT_ID    = grant_id;
  assign wr.WR_data     = grant_id ? wr.REQ1_DATA : wr.REQ0_DATA;
  assign wr.WR_addr     = wptr_bin_reg[ADDR_DATA-1:0];
  assign wr.WR_PTR_GRAY = wptr_gray_reg;
  assign wr.FULL        = full_reg;

  assign wptr_bin_next  = wptr_bin_reg + {{ADDR_DATA{1'b0}}, accept};
  assign wptr_gray_next = wptr_bin_next ^ (wptr_bin_next >> 1);
  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  assign full_match = {~wr.RD_PTR_SYNC[ADDR_DATA:ADDR_DATA-1], wr.RD_PTR_SYNC[ADDR_DATA-2:0]};

  always_ff @(posedge WR_CLK or negedge WR_RST) begin
    if (!WR_RST) begin
      wptr_bin_reg  <= '0;
      wptr_gray_reg <= '0;
      full_reg      <= 1'b0;
      last_reg      <= 1'b1;
    end else begin
      wptr_bin_reg  <= wptr_bin_next;
      wptr_gray_reg <= wptr_gray_next;
      full_reg      <= (wptr_gray_next == full_match);
      if (accept) begin
        last_reg <= grant_id;
      end
    end
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam logic [ADDR_DATA:0] AF_LIMIT = AF_THRESH[ADDR_DATA:0];

  logic [ADDR_DATA:0] rd_bin;
  logic [ADDR_DATA:0] occ_next;
  logic               af_reg;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi <= ADDR_DATA; gi++) begin : g_gray2bin
    assign rd_bin[gi] = ^(wr.RD_PTR_SYNC >> gi);
  end

  assign occ_next = wptr_bin_next - rd_bin;

  always_ff @(posedge WR_CLK or negedge WR_RST) begin
    if (!WR_RST) begin
      af_reg <= 1'b0;
    end else begin
      af_reg <= (occ_next >= AF_LIMIT);
    end
  end

  assign wr.ALMOST_FULL = af_reg;
`else
  assign wr.ALMOST_FULL = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus queues expected writes,
// a negedge monitor pops and compares each memory write the DUT issues.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int AW = 3;
`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam logic AF_ENABLED = 1'b1;
`else
  localparam logic AF_ENABLED = 1'b0;
`endif

  typedef struct {
    logic          gid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_DATA(AW)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_DATA(AW), .AF_THRESH(6)) dut (
    .WR_CLK(clk),
    .WR_RST(rst_n),
    .wr    (bus)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic expect_write(input logic gid, input int addr, input int data);
    wr_t e;
    e.gid  = gid;
    e.addr = addr[AW-1:0];
    e.data = data[DW-1:0];
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.REQ0_VALID  = 1'b0;
    bus.REQ1_VALID  = 1'b0;
    bus.RD_PTR_SYNC = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] gray4(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  // Monitor: every memory write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.WR_CLK_EN === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h grant %0d, expected no write at %0t",
                 bus.WR_addr, bus.WR_data, bus.GRANT_ID, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("grant_id", {31'd0, bus.GRANT_ID}, {31'd0, mon_e.gid});
        check("wr_addr", {29'd0, bus.WR_addr}, {29'd0, mon_e.addr});
        check("wr_data", {24'd0, bus.WR_data}, {24'd0, mon_e.data});
      end
    end
  end

  initial begin
    // 1. Reset with both requesters asserting VALID.
    bus.REQ0_VALID  = 1'b1;
    bus.REQ1_VALID  = 1'b1;
    bus.REQ0_DATA   = 8'h55;
    bus.REQ1_DATA   = 8'h66;
    bus.RD_PTR_SYNC = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", {31'd0, bus.REQ0_READY}, 0);
    check("rst_ready1", {31'd0, bus.REQ1_READY}, 0);
    check("rst_wr_en", {31'd0, bus.WR_CLK_EN}, 0);
    check("rst_full", {31'd0, bus.FULL}, 0);
    check("rst_gray", {28'd0, bus.WR_PTR_GRAY}, 32'h0);
    check("rst_almost_full", {31'd0, bus.ALMOST_FULL}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_write(1'b0, 0, 8'h55);
    step();
    bus.REQ0_VALID = 1'b0;
    bus.REQ1_VALID = 1'b0;

    // 2. Fill from requester 0 only.
    do_reset();
    bus.REQ0_VALID = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.REQ0_DATA = 8'h11 + i[7:0];
      expect_write(1'b0, i, 8'h11 + i);
      step();
    end
    bus.REQ0_DATA = 8'h19;
    check("fill_gray", {28'd0, bus.WR_PTR_GRAY}, 32'hC);
    check("fill_full", {31'd0, bus.FULL}, 1);
    check("fill_ready0_blocked", {31'd0, bus.REQ0_READY}, 0);
    step();
    step();
    check("fill_full_hold", {31'd0, bus.FULL}, 1);

    // 4. Release by one read, refill one word.
    bus.RD_PTR_SYNC = 4'b0001;
    expect_write(1'b0, 0, 8'h19);
    step();
    check("release_full", {31'd0, bus.FULL}, 0);
    check("release_ready0", {31'd0, bus.REQ0_READY}, 1);
    step();
    bus.REQ0_VALID = 1'b0;
    check("refill_full", {31'd0, bus.FULL}, 1);
    check("refill_gray", {28'd0, bus.WR_PTR_GRAY}, 32'hD);

    // 3. Round robin with both requesters valid.
    do_reset();
    bus.REQ0_VALID = 1'b1;
    bus.REQ1_VALID = 1'b1;
    bus.REQ0_DATA  = 8'hA0;
    bus.REQ1_DATA  = 8'hB0;
    expect_write(1'b0, 0, 8'hA0);
    expect_write(1'b1, 1, 8'hB0);
    expect_write(1'b0, 2, 8'hA0);
    expect_write(1'b1, 3, 8'hB0);
    repeat (4) step();
    bus.REQ0_VALID = 1'b0;
    bus.REQ1_VALID = 1'b0;
    check("rr_gray", {28'd0, bus.WR_PTR_GRAY}, 32'h6);

    // 5. Pointer wrap with the read pointer two words behind.
    do_reset();
    bus.REQ1_VALID = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.RD_PTR_SYNC = gray4((i >= 2) ? i - 2 : 0);
      bus.REQ1_DATA   = 8'hC0 + i[7:0];
      expect_write(1'b1, i % 8, 8'hC0 + i);
      step();
      check("wrap_no_full", {31'd0, bus.FULL}, 0);
      if (i == 7)  check("wrap_gray_8", {28'd0, bus.WR_PTR_GRAY}, 32'hC);
      if (i == 14) check("wrap_gray_15", {28'd0, bus.WR_PTR_GRAY}, 32'h8);
      if (i == 15) check("wrap_gray_16", {28'd0, bus.WR_PTR_GRAY}, 32'h0);
    end
    bus.REQ1_VALID = 1'b0;

    // 6. Almost full at six words.
    do_reset();
    bus.REQ0_VALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.REQ0_DATA = 8'h60 + i[7:0];
      expect_write(1'b0, i, 8'h60 + i);
      step();
      if (i == 4) check("af_after_5", {31'd0, bus.ALMOST_FULL}, 0);
    end
    bus.REQ0_VALID = 1'b0;
    check("af_after_6", {31'd0, bus.ALMOST_FULL}, {31'd0, AF_ENABLED});
    check("af_not_full", {31'd0, bus.FULL}, 0);

    repeat (2) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
